// File: rtl/clk_div_cond_if.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_cond_if
// Description : Bundle of the derived clocks produced by clk_div_cond.
//               master modport: driven by the divider.
//               slave  modport: consumed by the serializer/deserializer logic.
//               Signals: CLK_2, CLK_4, CLK_8 (and CLK_16 when
//               FREQ_DIV_COND_CLK16_EN is defined).
// Revision    : 1.0 - initial release
// ============================================================================
interface clk_div_cond_if;
    logic CLK_2;
    logic CLK_4;
    logic CLK_8;
`ifdef FREQ_DIV_COND_CLK16_EN
    logic CLK_16;

    modport master (output CLK_2, output CLK_4, output CLK_8, output CLK_16);
    modport slave  (input  CLK_2, input  CLK_4, input  CLK_8, input  CLK_16);
`else
    modport master (output CLK_2, output CLK_4, output CLK_8);
    modport slave  (input  CLK_2, input  CLK_4, input  CLK_8);
`endif
endinterface : clk_div_cond_if
`default_nettype wire

// File: rtl/clk_div_cond.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_cond
// Description : Synchronous power-of-two clock divider. A free-running
//               binary up-counter whose bits are the /2, /4 and /8 clocks.
//               Every output comes straight from a flop, so the derived
//               clocks are glitch-free and phase-aligned to rising CLK.
// Ports       : CLK    - master clock, all updates on its rising edge
//               reset  - asynchronous active-high reset, loads INIT
//               div_if - master modport carrying CLK_2 / CLK_4 / CLK_8
//                        (plus CLK_16 with the optional build)
// Parameters  : INIT   - counter reset value, bit0=CLK_2, bit1=CLK_4,
//                        bit2=CLK_8
// Options     : FREQ_DIV_COND_CLK16_EN - widens the counter to 4 bits and
//               adds CLK_16 (reset value 0)
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_cond #(
    parameter logic [2:0] INIT = 3'b000
) (
    input  wire logic      CLK,
    input  wire logic      reset,
    clk_div_cond_if.master div_if
);

`ifdef FREQ_DIV_COND_CLK16_EN
    localparam int unsigned          c_CNT_W     = 4;
    // The /16 stage always starts low regardless of INIT.
    localparam logic [c_CNT_W-1:0]   c_RESET_VAL = {1'b0, INIT};
`else
    localparam int unsigned          c_CNT_W     = 3;
    localparam logic [c_CNT_W-1:0]   c_RESET_VAL = INIT;
`endif

    logic [c_CNT_W-1:0] cnt_q;
    logic [c_CNT_W-1:0] cnt_d;

    // Natural binary rollover gives the modulo wrap for free.
    always_comb begin
        cnt_d = cnt_q + {{(c_CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            cnt_q <= c_RESET_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Pure wiring from the counter flops: no gates on the clock outputs.
    assign div_if.CLK_2  = cnt_q[0];
    assign div_if.CLK_4  = cnt_q[1];
    assign div_if.CLK_8  = cnt_q[2];
`ifdef FREQ_DIV_COND_CLK16_EN
    assign div_if.CLK_16 = cnt_q[3];
`endif

endmodule : clk_div_cond
`default_nettype wire

// File: tb/tb_clk_div_cond.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_clk_div_cond
// Description : Directed self-checking bench for clk_div_cond. Two DUTs:
//               one with default INIT, one with INIT=3'b110.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_cond;

    logic CLK    = 1'b0;
    logic reset  = 1'b1;
    logic reset2 = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    clk_div_cond_if u_if  ();
    clk_div_cond_if u_if2 ();

    clk_div_cond u_dut (
        .CLK    (CLK),
        .reset  (reset),
        .div_if (u_if)
    );

    clk_div_cond #(.INIT(3'b110)) u_dut_init (
        .CLK    (CLK),
        .reset  (reset2),
        .div_if (u_if2)
    );

    logic [2:0] w_out;
    logic [2:0] w_out2;
    assign w_out  = {u_if.CLK_8,  u_if.CLK_4,  u_if.CLK_2};
    assign w_out2 = {u_if2.CLK_8, u_if2.CLK_4, u_if2.CLK_2};

    // 1000 ns master clock period.
    always #500 CLK = ~CLK;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    // Bring the DUT into a known state and release reset between edges.
    task automatic reset_and_release();
        @(negedge CLK);
        reset = 1'b1;
        @(negedge CLK);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            n_checks++;
            if (w_out !== 3'b000) begin
                n_errors++;
                $display("FAIL reset_hold[%0d]: got %b, expected 000", i, w_out);
            end
        end
        // Let it count, then assert reset between edges.
        reset = 1'b0;
        repeat (3) @(negedge CLK);
        #100 reset = 1'b1;
        #1;
        n_checks++;
        if (w_out !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_async: got %b, expected 000", w_out);
        end
        // Reset asserted on the same timestep as a rising edge.
        @(negedge CLK);
        reset = 1'b0;
        repeat (2) @(negedge CLK);
        @(posedge CLK);
        reset = 1'b1;
        #1;
        n_checks++;
        if (w_out !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_coincident: got %b, expected 000", w_out);
        end
    endtask

    task automatic test_sequence();
        logic [2:0] exp;
        reset_and_release();
        for (int k = 1; k <= 16; k++) begin
            @(negedge CLK);
            exp = 3'(k % 8);
            n_checks++;
            if (w_out !== exp) begin
                n_errors++;
                $display("FAIL sequence edge %0d: got %b, expected %b", k, w_out, exp);
            end
        end
    endtask

    task automatic test_period_duty();
        time   last_rise [3];
        time   high_t    [3];
        time   period_t  [3];
        logic  prev      [3];
        logic  cur;
        for (int j = 0; j < 3; j++) begin
            last_rise[j] = 0;
            high_t[j]    = 0;
            period_t[j]  = 0;
        end
        reset_and_release();
        for (int j = 0; j < 3; j++) prev[j] = w_out[j];
        for (int k = 0; k < 64; k++) begin
            @(negedge CLK);
            for (int j = 0; j < 3; j++) begin
                cur = w_out[j];
                if (cur && !prev[j]) begin
                    if (last_rise[j] != 0) period_t[j] = $time - last_rise[j];
                    last_rise[j] = $time;
                end else if (!cur && prev[j] && last_rise[j] != 0) begin
                    high_t[j] = $time - last_rise[j];
                end
                prev[j] = cur;
            end
        end
        for (int j = 0; j < 3; j++) begin
            n_checks++;
            if (high_t[j] != (64'd1000 << j)) begin
                n_errors++;
                $display("FAIL high_time CLK_%0d: got %0t ns, expected %0d ns", 2 << j, high_t[j], 1000 << j);
            end
            n_checks++;
            if (period_t[j] != (64'd2000 << j)) begin
                n_errors++;
                $display("FAIL period CLK_%0d: got %0t ns, expected %0d ns", 2 << j, period_t[j], 2000 << j);
            end
        end
    endtask

    task automatic test_reset_mid_operation();
        reset_and_release();
        repeat (5) @(negedge CLK);
        n_checks++;
        if (w_out !== 3'b101) begin
            n_errors++;
            $display("FAIL mid_pre: got %b, expected 101", w_out);
        end
        #100 reset = 1'b1;
        #1;
        n_checks++;
        if (w_out !== 3'b000) begin
            n_errors++;
            $display("FAIL mid_reset_immediate: got %b, expected 000", w_out);
        end
        #298;
        n_checks++;
        if (w_out !== 3'b000) begin
            n_errors++;
            $display("FAIL mid_reset_hold: got %b, expected 000", w_out);
        end
        #1 reset = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (w_out !== 3'b001) begin
            n_errors++;
            $display("FAIL mid_restart: got %b, expected 001", w_out);
        end
    endtask

    task automatic test_init_param();
        @(negedge CLK);
        reset2 = 1'b1;
        @(negedge CLK);
        n_checks++;
        if (w_out2 !== 3'b110) begin
            n_errors++;
            $display("FAIL init_reset: got %b, expected 110", w_out2);
        end
        reset2 = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (w_out2 !== 3'b111) begin
            n_errors++;
            $display("FAIL init_edge1: got %b, expected 111", w_out2);
        end
        @(negedge CLK);
        n_checks++;
        if (w_out2 !== 3'b000) begin
            n_errors++;
            $display("FAIL init_edge2: got %b, expected 000", w_out2);
        end
    endtask

`ifdef FREQ_DIV_COND_CLK16_EN
    task automatic test_clk16();
        logic [3:0] exp;
        logic [3:0] got;
        reset_and_release();
        n_checks++;
        if (u_if.CLK_16 !== 1'b0) begin
            n_errors++;
            $display("FAIL clk16_reset: got %b, expected 0", u_if.CLK_16);
        end
        for (int k = 1; k <= 32; k++) begin
            @(negedge CLK);
            exp = 4'(k % 16);
            got = {u_if.CLK_16, w_out};
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL clk16 edge %0d: got %b, expected %b", k, got, exp);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_sequence();
        test_period_duty();
        test_reset_mid_operation();
        test_init_param();
`ifdef FREQ_DIV_COND_CLK16_EN
        test_clk16();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_clk_div_cond
`default_nettype wire

// File: doc/clk_div_cond.md
Name: clk_div_cond

Overview:
- Synchronous power-of-two clock divider: derives /2, /4 and /8 clocks from one master clock.
- Outputs are taken directly from flops, so they are glitch-free.
- Sits beside the parallel-to-serial / serial-to-parallel path and supplies its slower bit/word clocks (e.g. 2 MHz in -> 1 MHz, 500 kHz, 250 kHz).
- All outputs change only on the rising edge of CLK, so all three derived clocks stay phase-aligned.

Parameters:
- INIT, 3'b000, counter value loaded by reset. Bit 0 is the initial CLK_2 level, bit 1 the initial CLK_4 level, bit 2 the initial CLK_8 level.

Ports:
- CLK  input  1  master clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset; forces the counter to INIT immediately.
- CLK_2  output  1  CLK divided by 2, 50% duty.
- CLK_4  output  1  CLK divided by 4, 50% duty.
- CLK_8  output  1  CLK divided by 8, 50% duty.

Behaviour:
- One clock and one reset. Reset is asynchronous and active-high.
- Internal state: 3-bit up-counter q[2:0], each bit a flop.
- Output mapping: CLK_2=q[0], CLK_4=q[1], CLK_8=q[2]. No combinational logic between flops and output ports.
- Reset assert (reset=1): q<=INIT at once, without waiting for a CLK edge. Outputs hold INIT bits for as long as reset is high. Default: all outputs 0.
- Reset deassert: the first rising CLK edge after reset falls performs the first increment. There is no extra synchronizer latency.
- Normal operation: on each rising CLK edge, q<=q+1, modulo 8. 3'b111 wraps to 3'b000.
- Output timing with INIT=0:
  - CLK_2 toggles every edge.
  - CLK_4 toggles every 2nd edge.
  - CLK_8 toggles every 4th edge.
  - Periods are 2, 4 and 8 CLK periods.
- Alignment: every rising edge of CLK_4 coincides with a falling edge of CLK_2. Every rising edge of CLK_8 coincides with falling edges of CLK_4 and CLK_2.
- Edge-count sequence from reset release with INIT=0, as {CLK_8,CLK_4,CLK_2}: 001, 010, 011, 100, 101, 110, 111, 000, repeating.
- Reset mid-operation: asserting reset at any counter value returns q to INIT asynchronously, even mid-period. The sequence restarts from INIT after release.
- Reset held across CLK edges: no counting occurs.
- Reset and CLK edge coincident: reset wins.
- Outputs are never X after the first reset assertion.

Optional Feature:
- Macro: FREQ_DIV_COND_CLK16_EN.
- When defined:
  - Counter widens to 4 bits.
  - Extra output port CLK_16 (output, 1 bit) = q[3], CLK divided by 16, 50% duty, reset value 0.
  - Wrap becomes modulo 16.
  - CLK_2/CLK_4/CLK_8 behaviour is unchanged.
- When undefined: counter is 3 bits, the CLK_16 port does not exist, and the block is as specified above.

Test Plan:
- Reset check: hold reset=1 for 3 CLK periods with CLK toggling -> CLK_2=CLK_4=CLK_8=0 throughout. Assert reset between edges -> outputs 0 before the next CLK edge.
- Division sequence: release reset, apply 16 rising edges -> {CLK_8,CLK_4,CLK_2} follows 001..111,000, repeated twice, exactly one step per edge.
- Period/duty: 1000 ns CLK period, run 64 edges -> CLK_2 high 1000 ns / period 2000 ns; CLK_4 2000/4000 ns; CLK_8 4000/8000 ns.
- Reset mid-operation: after 5 edges (outputs 101), pulse reset for 300 ns between edges -> outputs 000 immediately. Next edge -> 001.
- INIT parameter: build with INIT=3'b110, reset -> outputs 110. After 2 edges -> 000.
- Optional feature: define FREQ_DIV_COND_CLK16_EN, release reset, run 32 edges -> CLK_16 rises at edge 8, falls at edge 16, rises at edge 24. CLK_8 is unchanged versus the build without the macro.
